// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction fetch queue feeding the decode stage. Issues sequential
//   word fetches to instruction memory, buffers returned words together
//   with their PCs in a DEPTH-entry FIFO, and presents the head entry over
//   a valid/ready handshake. A redirect flushes everything and restarts
//   fetch at the new PC.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req / imem_addr     fetch request and word-aligned address
//   imem_rvalid / imem_rdata read response, exactly one cycle after request
//   redirect / redirect_pc   flush and restart fetch at redirect_pc & ~3
//   inst_valid / inst_ready  head-entry handshake towards decode
//   inst / inst_pc           head instruction word and its PC
//   inst_illegal             head opcode unsupported
//   ifq_count                current FIFO occupancy
//
// Build option
//   IFQ_OPCODE_CHECK_EN  when defined, inst_illegal flags a valid head whose
//                        opcode is not in the supported set; otherwise 0.

module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc,
    output logic                   inst_illegal,
    output logic [$clog2(DEPTH):0] ifq_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic [31:0]   r_word [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_used;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    // A request is only issued when an entry is guaranteed free for its
    // response, so a push can never hit a full FIFO. Gating with rst_n keeps
    // imem_req low while reset is held.
    always_comb begin
        w_used     = r_count + CW'(r_inflight);
        w_issue    = rst_n & ~redirect & (w_used < CW'(DEPTH));
        inst_valid = (r_count != '0) & ~redirect;
        w_push     = imem_rvalid & r_inflight & ~redirect;
        w_pop      = inst_valid & inst_ready;
        imem_req   = w_issue;
        imem_addr  = r_fetch_pc;
        inst       = r_word[r_rd_ptr];
        inst_pc    = r_pc[r_rd_ptr];
        ifq_count  = r_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            // Clearing inflight drops the response to any pre-redirect request.
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            // Memory answers exactly one cycle after a request, so the
            // inflight flag simply tracks whether a request went out.
            r_inflight <= w_issue;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_word[PW'(i)] <= '0;
                r_pc[PW'(i)]   <= '0;
            end
        end else if (w_push) begin
            r_word[r_wr_ptr] <= imem_rdata;
            r_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

`ifdef IFQ_OPCODE_CHECK_EN
    logic w_opcode_ok;

    always_comb begin
        w_opcode_ok = 1'b0;
        case (inst[6:0])
            7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011: w_opcode_ok = 1'b1;
            default:                                         w_opcode_ok = 1'b0;
        endcase
        inst_illegal = inst_valid & ~w_opcode_ok;
    end
`else
    always_comb begin
        inst_illegal = 1'b0;
    end
`endif

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue that produces the 32-bit instruction stream consumed by the control-unit decoder and the rest of the decode stage. It issues sequential word fetches to instruction memory, buffers returned words with their PCs in a small FIFO, and presents them one at a time over a valid/ready handshake. A redirect input from branch/jump resolution flushes the queue and restarts fetch at a new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request this cycle; memory always accepts
- imem_addr  output  32  word-aligned fetch address, valid when imem_req=1
- imem_rvalid  input  1  read data valid; asserted exactly 1 cycle after each accepted request
- imem_rdata  input  32  fetched instruction word
- redirect  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 00
- inst_valid  output  1  head entry available to decode
- inst_ready  input  1  decode accepts head entry
- inst  output  32  head instruction word
- inst_pc  output  32  PC of head instruction
- inst_illegal  output  1  head opcode not a supported opcode (see Configuration)
- ifq_count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State: fetch_pc (32b), inflight flag plus captured request PC, FIFO storage (word + PC per entry), read/write pointers, occupancy count.
- Reset values: fetch_pc=RESET_PC, FIFO empty, inflight=0; imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_illegal=0, ifq_count=0.
- Issue rule: imem_req=1 when redirect=0 and count+inflight < DEPTH. On issue: captured PC <= fetch_pc, inflight <= 1, fetch_pc <= fetch_pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
- Response: imem_rvalid with inflight=1 pushes {imem_rdata, captured PC} into FIFO. Credit rule guarantees a free entry; push on full cannot occur. imem_rvalid with inflight=0 is ignored.
- Pop: inst_valid & inst_ready removes head. Push and pop in the same cycle: count unchanged, both pointers advance.
- inst_valid = (count != 0) & ~redirect; inst/inst_pc show head entry combinationally.
- Redirect (highest priority): in that cycle imem_req=0, inst_valid=0 (no transfer), and at the edge FIFO empties, inflight clears, any response arriving next cycle for the pre-redirect request is dropped, fetch_pc <= {redirect_pc[31:2],2'b00}. Back-to-back redirects: last one wins.
- Pointers wrap modulo DEPTH.

## Timing
- Fetch-to-decode latency: request in cycle N, rvalid in N+1, inst_valid in N+2.
- After reset release: imem_req=1 with RESET_PC in the first cycle, inst_valid first asserted 2 cycles later.
- Redirect in cycle R: request to redirect_pc in R+1, inst_valid for it in R+3.
- Sustained throughput 1 instruction/cycle with inst_ready held high.
- inst_ready low: fetch continues until count+inflight=DEPTH, then imem_req deasserts; resumes the cycle after a pop frees a credit.
- rst_n assertion mid-operation immediately returns all state and outputs to reset values; in-flight responses after reset release are dropped (inflight=0).

## Configuration
- IFQ_OPCODE_CHECK_EN defined: inst_illegal = inst_valid & (inst[6:0] not one of 0110011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 0010011). Decode uses it to raise an illegal-instruction trap instead of emitting all-zero controls.
- Not defined: inst_illegal tied to 0; no check logic.

## Test plan
- Reset release, RESET_PC=0, memory returns addr as data, inst_ready=1 -> imem_addr 0,4,8,... one per cycle; inst_valid from cycle 3 with inst_pc=0,4,8 and inst=inst_pc.
- inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, ifq_count=4, imem_req=0; raise inst_ready -> entries drain in PC order 0,4,8,12, fetch resumes at 16.
- Redirect to 32'h0000_0103 while FIFO holds 3 entries and a request is in flight -> next request addr 32'h0000_0100, stale response dropped, next accepted inst_pc=32'h100.
- fetch_pc=32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IFQ_OPCODE_CHECK_EN, memory returns 32'h0000_0073 then 32'h0000_0033 -> inst_illegal=1 then 0; without macro both 0.
- rst_n pulsed low with FIFO full and request in flight -> all outputs reset immediately; refetch starts at RESET_PC, no stale entry appears.
